// File: rtl/fetch_reg_pkg.sv
// Shared CPU package: fetch/decode defaults, FSM encoding, exception codes
// and the F/D pipeline register payload.
package fetch_reg_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned EXC_W = 5;

   localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;
   localparam logic [XLEN-1:0] DEF_IM_BASE    = 32'h0000_3000;
   localparam logic [XLEN-1:0] DEF_IM_LIMIT   = 32'h0000_6FFC;

   localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic             valid;
      logic [EXC_W-1:0] excode;
   } fd_reg_t;

   // An all-zero F/D entry is the pipeline bubble.
   localparam fd_reg_t FD_BUBBLE = '0;

endpackage

// File: rtl/fetch_addr_chk.sv
// Fetch-address legality check: flags misaligned or out-of-range PCs.
// Ports: F_PC (address in), F_adel (combinational address error out).
module fetch_addr_chk
   import fetch_reg_pkg::*;
#(
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
   input  logic [31:0] F_PC,
   output logic        F_adel
);

   // Unsigned compares; the range is inclusive at both ends.
   assign F_adel = (F_PC[1:0] != 2'b00) || (F_PC < IM_BASE) || (F_PC > IM_LIMIT);

endmodule

// File: rtl/fetch_reg.sv
// Fetch PC register plus F/D pipeline register with a BOOT/RUN FSM.
// Ports: clk, rst_n (async active-low); npc, epc next/return PCs;
// stall, flush, exc_req, eret_req control; im_instr fetched word;
// F_PC fetch PC, F_adel fetch address error (combinational);
// D_PC, D_Instr, D_valid, D_excode decode-stage contents.
module fetch_reg
   import fetch_reg_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
   parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT   = DEF_IM_LIMIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        flush,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic [31:0] im_instr,
   output logic [31:0] F_PC,
   output logic        F_adel,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic        D_valid,
   output logic [4:0]  D_excode
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   fd_reg_t      fd_q, fd_d;
   fd_reg_t      fd_cap;
   logic         adel;

   fetch_addr_chk #(
      .IM_BASE  (IM_BASE),
      .IM_LIMIT (IM_LIMIT)
   ) u_addr_chk (
      .F_PC   (pc_q),
      .F_adel (adel)
   );

   // Entry captured from the current fetch; a bad address yields an AdEL slot.
   always_comb begin
      fd_cap        = FD_BUBBLE;
      fd_cap.pc     = pc_q;
      fd_cap.valid  = 1'b1;
      fd_cap.instr  = adel ? 32'h0 : im_instr;
      fd_cap.excode = adel ? EXC_ADEL : EXC_NONE;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_BOOT;
      else        state_q <= state_d;
   end

   // Next state, next PC and next F/D contents.
   always_comb begin
      state_d = ST_RUN;
      pc_d    = pc_q;
      fd_d    = fd_q;
      if (state_q == ST_BOOT) begin
         pc_d = RESET_PC;
         fd_d = FD_BUBBLE;
      end else if (exc_req) begin
         pc_d = HANDLER_PC;
         fd_d = FD_BUBBLE;
      end else if (eret_req) begin
         pc_d = epc;
         fd_d = FD_BUBBLE;
      end else if (flush) begin
         // Flush empties D but a concurrent stall still freezes the PC.
         if (!stall) pc_d = npc;
         fd_d = FD_BUBBLE;
      end else if (!stall) begin
         pc_d = npc;
         fd_d = fd_cap;
      end
   end

   // PC and F/D registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
         fd_q <= FD_BUBBLE;
      end else begin
         pc_q <= pc_d;
         fd_q <= fd_d;
      end
   end

   assign F_PC     = pc_q;
   assign F_adel   = adel;
   assign D_PC     = fd_q.pc;
   assign D_Instr  = fd_q.instr;
   assign D_valid  = fd_q.valid;
   assign D_excode = fd_q.excode;

endmodule
